conv_tile_sequencer: RTL
========================

// Module: conv_tile_sequencer
// PURPOSE
//  Initiator/driver side of the fast-convolution tile interface.
//  - Buffers a raster pixel stream into an IMG_H x IMG_W frame.
//  - Walks 5x5 tiles with stride 3, presents each tile on param25 and pulses conv start.
//  - Waits for conv data_valid, then writes the 3x3 param9 result as 9 sequential
//    output-map writes.
//  - Sits between the pixel source and the conv engine; weights are wired to the engine directly.
// PARAMETERS
//  IMG_W       11    input width in pixels; must satisfy (IMG_W-5)%3==0 (elaboration error otherwise)
//  IMG_H       11    input height in pixels; must satisfy (IMG_H-5)%3==0
//  DATA_W      16    pixel width; must equal the packConv element width
//  TIMEOUT_CYC 64    watchdog limit in cycles (used only with CONV_TILE_TIMEOUT_EN)
//  Derived:
//   TX=(IMG_W-5)/3+1, TY=(IMG_H-5)/3+1
//   OUT_W=3*TX, OUT_H=3*TY
//   AW=$clog2(OUT_W*OUT_H)
// PORTS
//  clk         in   1        clock
//  reset       in   1        synchronous, active-high reset
//  run         in   1        start one frame; sampled only in IDLE
//  pix_valid   in   1        input pixel valid
//  pix_data    in   DATA_W   input pixel, raster order (row 0 col 0 first)
//  pix_ready   out  1        high only in LOAD; a pixel transfers when pix_valid&&pix_ready
//  tile_map    out  param25  current 5x5 tile, row-major (element r*5+c)
//  conv_start  out  1        one-cycle start pulse to the conv engine
//  conv_map    in   param9   conv result, row-major 3x3
//  conv_valid  in   1        conv result valid (one-cycle pulse)
//  ofm_we      out  1        output-map write enable
//  ofm_addr    out  AW       output-map address
//  ofm_data    out  DATA_W   output-map write data
//  busy        out  1        high in every state except IDLE
//  done        out  1        one-cycle pulse after the last tile is written
//  error       out  1        sticky watchdog flag; cleared by reset or by accepted run
// BEHAVIOUR
//  Reset (sync): state=IDLE; all outputs 0; tile/pixel/write counters 0.
//  Frame buffer contents are don't-care after reset.
//  FSM:
//   IDLE  -> LOAD on run (clears error); run outside IDLE is ignored.
//   LOAD  pix_ready=1; store pixel at counter, counter++.
//         After the IMG_W*IMG_H-th accepted pixel -> FETCH (pix_ready=0 that next cycle).
//   FETCH register tile_map: element r*5+c = pixel[(3*ty+r)*IMG_W + 3*tx+c] -> START.
//   START conv_start=1 for exactly this cycle -> WAIT.
//   WAIT  on conv_valid: latch conv_map into a result register -> WRITE.
//   WRITE 9 cycles, i=0..8:
//         ofm_we=1; ofm_data=result[i]; ofm_addr=(3*ty+i/3)*OUT_W + 3*tx + i%3.
//         After i=8 -> NEXT.
//   NEXT  tx++; on tx wrap (TX-1 -> 0) ty++.
//         Last tile (tx=TX-1, ty=TY-1) -> DONE; otherwise -> FETCH.
//   DONE  done=1 for one cycle -> IDLE.
//  Handshake and conv interface rules:
//   - tile_map is held stable from START until WAIT exits; the engine samples it one
//     cycle after conv_start.
//   - conv_valid outside WAIT is ignored; conv_valid coincident with conv_start is ignored.
//   - At most one tile is outstanding at the conv engine at any time.
//  Timing:
//   - Tile cost = 1 (FETCH) + 1 (START) + W (WAIT) + 9 (WRITE) + 1 (NEXT) cycles.
//   - Total frame time = IMG_W*IMG_H + TX*TY*tile cost + 1.
//  Data: pixels and results are passed unmodified; no arithmetic other than address generation.
//  Reset mid-frame: abort immediately to IDLE; no done pulse, no further ofm writes.
// CONFIGURATION
//  CONV_TILE_TIMEOUT_EN defined:
//   - Watchdog counts cycles in WAIT.
//   - Reaching TIMEOUT_CYC without conv_valid sets error=1 and goes to IDLE; no done pulse.
//   - Remaining tiles are skipped.
//  CONV_TILE_TIMEOUT_EN undefined:
//   - No watchdog; WAIT has no time limit.
//   - error is tied to 0; TIMEOUT_CYC is unused.
// TESTING
//  1 Frame: 11x11, pixel k=k, conv model returns tile elems {6,7,8,11,12,13,16,17,18}
//    after 9 cycles -> 81 writes; ofm[r*9+c] == pixel[(r+1)*11+c+1]; one done pulse;
//    busy low afterwards.
//  2 Tile order: 11x11 frame -> 9 conv_start pulses; tile 0 elem0=pixel 0;
//    tile 1 elem0=pixel 3; tile 3 elem0=pixel 33; tile 8 elem24=pixel 120.
//  3 Backpressure: pix_valid toggled every other cycle -> exactly 121 pixels stored;
//    pixels offered after LOAD ends are not taken (pix_ready=0); output identical to test 1.
//  4 Misuse: run pulsed during WAIT and a spurious conv_valid during WRITE ->
//    no restart, no extra writes; frame completes with 81 writes.
//  5 Reset mid-frame: reset asserted in WRITE of tile 4 -> next cycle IDLE,
//    all outputs 0; a new run completes a full frame correctly.
//  6 [CONV_TILE_TIMEOUT_EN, TIMEOUT_CYC=64] conv model never responds ->
//    error=1 after 64 WAIT cycles; state IDLE; no done; 0 writes.

Source files
------------

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer
// Buffers one raster frame, walks 5x5 tiles at stride 3 through an external
// conv engine, and writes each 3x3 result into the output map.
// Build option: define CONV_TILE_TIMEOUT_EN to add a WAIT-state watchdog that
// raises a sticky error and abandons the frame after TIMEOUT_CYC cycles.
module conv_tile_sequencer #(
  parameter  int unsigned IMG_W       = 11,
  parameter  int unsigned IMG_H       = 11,
  parameter  int unsigned DATA_W      = 16,
  parameter  int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned TX          = (IMG_W - 5) / 3 + 1,
  localparam int unsigned TY          = (IMG_H - 5) / 3 + 1,
  localparam int unsigned OUT_W       = 3 * TX,
  localparam int unsigned OUT_H       = 3 * TY,
  localparam int unsigned AW          = $clog2(OUT_W * OUT_H)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    pix_valid,
  input  logic [DATA_W-1:0]       pix_data,
  output logic                    pix_ready,
  output logic [24:0][DATA_W-1:0] tile_map,
  output logic                    conv_start,
  input  logic [8:0][DATA_W-1:0]  conv_map,
  input  logic                    conv_valid,
  output logic                    ofm_we,
  output logic [AW-1:0]           ofm_addr,
  output logic [DATA_W-1:0]       ofm_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned FBW  = $clog2(NPIX);
  localparam int unsigned PCW  = $clog2(NPIX + 1);
  localparam int unsigned TXW  = $clog2(TX + 1);
  localparam int unsigned TYW  = $clog2(TY + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Reject frame geometries that the stride-3 tiling cannot cover exactly.
  generate
    if ((IMG_W < 5) || (((IMG_W - 5) % 3) != 0)) begin : g_bad_img_w
      $error("conv_tile_sequencer: IMG_W-5 must be a non-negative multiple of 3");
    end
    if ((IMG_H < 5) || (((IMG_H - 5) % 3) != 0)) begin : g_bad_img_h
      $error("conv_tile_sequencer: IMG_H-5 must be a non-negative multiple of 3");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("conv_tile_sequencer: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  // Control state
  logic [2:0]             state_q, state_d;
  logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [TXW-1:0]         tx_q, tx_d;
  logic [TYW-1:0]         ty_q, ty_d;
  logic [1:0]             wr_r_q, wr_r_d;
  logic [1:0]             wr_c_q, wr_c_d;
  logic [8:0][DATA_W-1:0] res_q, res_d;

  // Registered outputs
  logic                    pix_ready_q, pix_ready_d;
  logic                    conv_start_q, conv_start_d;
  logic                    ofm_we_q, ofm_we_d;
  logic [AW-1:0]           ofm_addr_q, ofm_addr_d;
  logic [DATA_W-1:0]       ofm_data_q, ofm_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [24:0][DATA_W-1:0] tile_map_q, tile_map_d;

  // Frame buffer (no reset; contents are rewritten every frame)
  logic [DATA_W-1:0] fb_q [NPIX];
  logic              fb_we;
  logic [FBW-1:0]    fb_waddr;
  logic              pix_acc;
  logic [3:0]        res_idx;
  logic [31:0]       fetch_base;

`ifdef CONV_TILE_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           error_q, error_d;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign pix_acc    = pix_ready_q && pix_valid;
  assign fetch_base = 32'(ty_q) * 32'(3 * IMG_W) + 32'(tx_q) * 32'd3;

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    wr_r_d    = wr_r_q;
    wr_c_d    = wr_c_q;
    res_d     = res_q;
    fb_we     = 1'b0;
    fb_waddr  = FBW'(pix_cnt_q);
`ifdef CONV_TILE_TIMEOUT_EN
    wd_cnt_d  = wd_cnt_q;
    error_d   = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
          tx_d      = '0;
          ty_d      = '0;
`ifdef CONV_TILE_TIMEOUT_EN
          error_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (pix_acc) begin
          fb_we     = 1'b1;
          pix_cnt_d = pix_cnt_q + PCW'(1);
          if (pix_cnt_q == PCW'(NPIX - 1)) begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef CONV_TILE_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (conv_valid) begin
          res_d   = conv_map;
          wr_r_d  = '0;
          wr_c_d  = '0;
          state_d = S_WRITE;
        end
`ifdef CONV_TILE_TIMEOUT_EN
        else if (wd_cnt_q == WDW'(TIMEOUT_CYC - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
`endif
      end
      S_WRITE: begin
        if (wr_c_q == 2'd2) begin
          wr_c_d = '0;
          if (wr_r_q == 2'd2) begin
            wr_r_d  = '0;
            state_d = S_NEXT;
          end else begin
            wr_r_d = wr_r_q + 2'd1;
          end
        end else begin
          wr_c_d = wr_c_q + 2'd1;
        end
      end
      S_NEXT: begin
        if (tx_q == TXW'(TX - 1)) begin
          tx_d = '0;
          if (ty_q == TYW'(TY - 1)) begin
            ty_d    = '0;
            state_d = S_DONE;
          end else begin
            ty_d    = ty_q + TYW'(1);
            state_d = S_FETCH;
          end
        end else begin
          tx_d    = tx_q + TXW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so each output lines up with its state
  always_comb begin
    pix_ready_d  = (state_d == S_LOAD);
    conv_start_d = (state_d == S_START);
    ofm_we_d     = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    ofm_addr_d   = '0;
    ofm_data_d   = '0;
    tile_map_d   = tile_map_q;
    res_idx      = 4'(wr_r_d) * 4'd3 + 4'(wr_c_d);
    if (state_d == S_WRITE) begin
      ofm_data_d = res_d[res_idx];
      ofm_addr_d = AW'((32'(ty_q) * 32'd3 + 32'(wr_r_d)) * OUT_W
                       + 32'(tx_q) * 32'd3 + 32'(wr_c_d));
    end
    if (state_q == S_FETCH) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          tile_map_d[5'(r * 5 + c)] = fb_q[FBW'(fetch_base + 32'(r) * IMG_W + 32'(c))];
        end
      end
    end
  end

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (fb_we) begin
      fb_q[fb_waddr] <= pix_data;
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      wr_r_q       <= '0;
      wr_c_q       <= '0;
      res_q        <= '0;
      pix_ready_q  <= 1'b0;
      conv_start_q <= 1'b0;
      ofm_we_q     <= 1'b0;
      ofm_addr_q   <= '0;
      ofm_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tile_map_q   <= '0;
`ifdef CONV_TILE_TIMEOUT_EN
      wd_cnt_q     <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      wr_r_q       <= wr_r_d;
      wr_c_q       <= wr_c_d;
      res_q        <= res_d;
      pix_ready_q  <= pix_ready_d;
      conv_start_q <= conv_start_d;
      ofm_we_q     <= ofm_we_d;
      ofm_addr_q   <= ofm_addr_d;
      ofm_data_q   <= ofm_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tile_map_q   <= tile_map_d;
`ifdef CONV_TILE_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  assign pix_ready  = pix_ready_q;
  assign conv_start = conv_start_q;
  assign ofm_we     = ofm_we_q;
  assign ofm_addr   = ofm_addr_q;
  assign ofm_data   = ofm_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tile_map   = tile_map_q;

endmodule
